// File: rtl/sram_b_arb_pkg.sv
// Shared defaults and index helper for the sram_b bank arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package sram_b_arb_pkg;

  localparam int ABITS_DEF     = 17;
  localparam int DBITS_DEF     = 8;
  localparam int STALL_MAX_DEF = 3;

  // Position k steps past base on a ring of n slots (base < n, k <= n).
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned k,
                                          input int unsigned n);
    int unsigned s;
    s = base + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/sram_b_17abits_arbiter_rr_arbiter.sv
// Round-robin arbiter: request vector + rotating pointer -> one-hot grant and index.
// Latency: grant is combinational; pointer advances on the accepting clock edge.
// Backpressure: pointer holds until the caller accepts the offered winner.
module rr_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] pos;

  // First requester found scanning upward from the pointer, wrapping at N.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'(rr_wrap(32'(ptr), 32'(k), N));
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

  // Pointer moves one past the accepted winner so it gets lowest priority next.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= IW'(rr_wrap(32'(idx), 1, N));
    end
  end

endmodule

// File: rtl/sram_b_17abits_arbiter.sv
// Shares one 1w:1r sram_b bank between NREQ requesters with independent RR write/read arbitration.
// Latency: write issues in the grant cycle; read data returns exactly 1 cycle after rd_gnt.
// Backpressure: requests wait ungranted; a read hitting a live write to its address stalls, and the write port yields one cycle after STALL_MAX stalls.
module sram_b_17abits_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ABITS     = ABITS_DEF,
  parameter int DBITS     = DBITS_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [NREQ-1:0]       wr_req,
  output logic [NREQ-1:0]       wr_gnt,
  input  logic [NREQ*ABITS-1:0] wr_addr,
  input  logic [NREQ*DBITS-1:0] wr_data,
  input  logic [NREQ*DBITS-1:0] wr_mask,
  input  logic [NREQ-1:0]       rd_req,
  output logic [NREQ-1:0]       rd_gnt,
  input  logic [NREQ*ABITS-1:0] rd_addr,
  output logic [NREQ-1:0]       rd_valid,
  output logic [DBITS-1:0]      rd_data,
  output logic                  CE0,
  output logic [ABITS-1:0]      A0,
  output logic [DBITS-1:0]      D0,
  output logic                  WE0,
  output logic [DBITS-1:0]      WEM0,
  output logic                  CE1,
  output logic [ABITS-1:0]      A1,
  input  logic [DBITS-1:0]      Q1
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  logic [NREQ-1:0]  wr_oh, rd_oh;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             wr_any, rd_any;
  logic             wr_fire, rd_fire, collide, yield;
  logic [SW-1:0]    stall_cnt;
  logic [ABITS-1:0] w_addr, r_addr;
  logic [DBITS-1:0] w_data, w_mask;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_wr_arb (
    .CLK(CLK), .RSTN(RSTN), .req(wr_req), .accept(wr_fire),
    .gnt(wr_oh), .idx(wr_idx), .any(wr_any)
  );

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rd_arb (
    .CLK(CLK), .RSTN(RSTN), .req(rd_req), .accept(rd_fire),
    .gnt(rd_oh), .idx(rd_idx), .any(rd_any)
  );

  assign w_addr = wr_addr[wr_idx*ABITS +: ABITS];
  assign w_data = wr_data[wr_idx*DBITS +: DBITS];
  assign w_mask = wr_mask[wr_idx*DBITS +: DBITS];
  assign r_addr = rd_addr[rd_idx*ABITS +: ABITS];

  // A starved read takes the cycle: the write port stands down for one grant slot.
  assign yield   = (stall_cnt == SW'(STALL_MAX));
  assign wr_fire = RSTN & wr_any & ~yield;
  // Only a write that actually changes bits at the read address blocks the read.
  assign collide = wr_fire & rd_any & (w_addr == r_addr) & (|w_mask);
  assign rd_fire = RSTN & rd_any & ~collide;

  assign wr_gnt = wr_fire ? wr_oh : '0;
  assign CE0    = wr_fire;
  assign WE0    = wr_fire;
  assign A0     = wr_fire ? w_addr : '0;
  assign D0     = wr_fire ? w_data : '0;
  assign WEM0   = wr_fire ? w_mask : '0;

  assign rd_gnt = rd_fire ? rd_oh : '0;
  assign CE1    = rd_fire;
  assign A1     = rd_fire ? r_addr : '0;

  // The memory's registered output is broadcast; rd_valid says whose it is.
  assign rd_data = Q1;

  // Count consecutive collision stalls of the pending read; any grant or idle read clears it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt <= '0;
    end else if (rd_fire || !rd_any) begin
      stall_cnt <= '0;
    end else if (collide && !yield) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  // Tag the returning read data with the requester granted last cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_fire ? rd_oh : '0;
    end
  end

endmodule

// File: tb/tb_sram_b_17abits_arbiter.sv
module tb_sram_b_17abits_arbiter;

  localparam int N    = 4;
  localparam int AB   = 17;
  localparam int DB   = 8;
  localparam int SMAX = 3;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic [N-1:0]    wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [N*AB-1:0] wr_addr, rd_addr;
  logic [N*DB-1:0] wr_data, wr_mask;
  logic [DB-1:0]   rd_data, D0, WEM0;
  logic [DB-1:0]   Q1 = '0;
  logic            CE0, WE0, CE1;
  logic [AB-1:0]   A0, A1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  sram_b_17abits_arbiter #(.NREQ(N), .ABITS(AB), .DBITS(DB), .STALL_MAX(SMAX)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  // ---------------- memory contents: SRAM pins model and reference copy ----------------
  logic [7:0] sram    [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] sram_rd(input int a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge CLK) begin
    if (CE1) Q1 <= sram_rd(int'(A1));
    if (CE0 && WE0) sram[int'(A0)] = (sram_rd(int'(A0)) & ~WEM0) | (D0 & WEM0);
  end

  // ---------------- reference model (arbitration rules in plain arithmetic) ----------------
  int          m_wptr, m_rptr, m_stall;
  logic [N-1:0] m_rvalid;
  logic [7:0]  m_rdata;
  int          e_w, e_r;
  bit          e_wi, e_ri, e_col;

  function automatic logic [AB-1:0] wa(input int i); return wr_addr[i*AB +: AB]; endfunction
  function automatic logic [AB-1:0] ra(input int i); return rd_addr[i*AB +: AB]; endfunction
  function automatic logic [DB-1:0] wd(input int i); return wr_data[i*DB +: DB]; endfunction
  function automatic logic [DB-1:0] wm(input int i); return wr_mask[i*DB +: DB]; endfunction

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_stall = 0; m_rvalid = '0; m_rdata = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluate expected outputs for the current inputs and compare (CLK low).
  task automatic settle_check();
    #1;
    e_w = -1;
    e_r = -1;
    for (int k = 0; k < N; k++) begin
      if (e_w < 0 && wr_req[(m_wptr + k) % N]) e_w = (m_wptr + k) % N;
      if (e_r < 0 && rd_req[(m_rptr + k) % N]) e_r = (m_rptr + k) % N;
    end
    e_wi  = (e_w >= 0) && (m_stall != SMAX);
    e_col = e_wi && (e_r >= 0) && (wa(e_w) == ra(e_r)) && (wm(e_w) != 0);
    e_ri  = (e_r >= 0) && !e_col;
    chk("m_wr_gnt", 32'(wr_gnt), e_wi ? (32'd1 << e_w) : 32'd0);
    chk("m_ce0",    32'(CE0),    32'(e_wi));
    chk("m_we0",    32'(WE0),    32'(e_wi));
    chk("m_a0",     32'(A0),     e_wi ? 32'(wa(e_w)) : 32'd0);
    chk("m_d0",     32'(D0),     e_wi ? 32'(wd(e_w)) : 32'd0);
    chk("m_wem0",   32'(WEM0),   e_wi ? 32'(wm(e_w)) : 32'd0);
    chk("m_rd_gnt", 32'(rd_gnt), e_ri ? (32'd1 << e_r) : 32'd0);
    chk("m_ce1",    32'(CE1),    32'(e_ri));
    if (e_ri) chk("m_a1", 32'(A1), 32'(ra(e_r)));
    chk("m_rd_valid", 32'(rd_valid), 32'(m_rvalid));
    if (m_rvalid != 0) chk("m_rd_data", 32'(rd_data), 32'(m_rdata));
  endtask

  // Commit one clock edge in the model, then return to CLK low.
  task automatic clk_adv();
    @(posedge CLK);
    if (e_ri) begin
      m_rdata  = ref_rd(int'(ra(e_r)));
      m_rvalid = N'(1 << e_r);
      m_rptr   = (e_r + 1) % N;
    end else begin
      m_rvalid = '0;
    end
    if (e_wi) begin
      ref_mem[int'(wa(e_w))] = (ref_rd(int'(wa(e_w))) & ~wm(e_w)) | (wd(e_w) & wm(e_w));
      m_wptr = (e_w + 1) % N;
    end
    if (e_ri || e_r < 0) m_stall = 0;
    else if (e_col && m_stall < SMAX) m_stall = m_stall + 1;
    @(negedge CLK);
  endtask

  task automatic set_wr(input int i, input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [DB-1:0] m);
    wr_addr[i*AB +: AB] = a;
    wr_data[i*DB +: DB] = d;
    wr_mask[i*DB +: DB] = m;
  endtask

  task automatic set_rd(input int i, input logic [AB-1:0] a);
    rd_addr[i*AB +: AB] = a;
  endtask

  task automatic default_fields();
    for (int i = 0; i < N; i++) begin
      set_wr(i, AB'(32'h100 + i), DB'(8'h10 + i), 8'hFF);
      set_rd(i, AB'(32'h200 + i));
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    model_reset();
  endtask

  // ---------------- round-robin vector table ----------------
  typedef struct {
    logic [N-1:0] wr_req;
    logic [N-1:0] rd_req;
    logic [N-1:0] exp_wg;
    logic [N-1:0] exp_rg;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000};
    vecs[8]  = '{4'b0000, 4'b1010, 4'b0000, 4'b0010};
    vecs[9]  = '{4'b0000, 4'b1010, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0101, 4'b1010, 4'b0001, 4'b0010};
    vecs[11] = '{4'b0101, 4'b1010, 4'b0100, 4'b1000};

    RSTN = 1'b0;
    wr_req = '0; rd_req = '0;
    default_fields();
    model_reset();
    @(negedge CLK);

    // Grants and enables are held off while reset is asserted.
    wr_req = 4'b1111; rd_req = 4'b1111;
    #1;
    chk("rst_wr_gnt", 32'(wr_gnt), 0);
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    chk("rst_ce0",    32'(CE0), 0);
    chk("rst_ce1",    32'(CE1), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    @(negedge CLK);
    wr_req = '0; rd_req = '0;
    RSTN = 1'b1;
    @(negedge CLK);

    // Reset asserted while a read is being granted: the read is dropped.
    rd_req = 4'b0010;
    settle_check();
    chk("midrd_gnt", 32'(rd_gnt), 32'b0010);
    RSTN = 1'b0;
    #1;
    chk("midrd_gnt_in_rst", 32'(rd_gnt), 0);
    chk("midrd_ce1_in_rst", 32'(CE1), 0);
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    rd_req = '0;
    model_reset();
    settle_check();
    chk("midrd_no_valid", 32'(rd_valid), 0);
    clk_adv();
    settle_check();
    chk("midrd_no_valid2", 32'(rd_valid), 0);
    clk_adv();

    // First grants after reset go to requester 0.
    wr_req = 4'b1111; rd_req = 4'b1111;
    settle_check();
    chk("first_wr_gnt", 32'(wr_gnt), 32'b0001);
    chk("first_rd_gnt", 32'(rd_gnt), 32'b0001);
    clk_adv();
    wr_req = '0; rd_req = '0;

    // Round-robin table from a fresh reset.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      wr_req = vecs[v].wr_req;
      rd_req = vecs[v].rd_req;
      settle_check();
      chk($sformatf("vec%0d_wr_gnt", v), 32'(wr_gnt), 32'(vecs[v].exp_wg));
      chk($sformatf("vec%0d_rd_gnt", v), 32'(rd_gnt), 32'(vecs[v].exp_rg));
      for (int b = 0; b < N; b++)
        if (vecs[v].exp_wg[b]) chk($sformatf("vec%0d_a0", v), 32'(A0), 32'h100 + b);
      clk_adv();
    end
    wr_req = '0; rd_req = '0;

    // Read latency and return routing.
    set_wr(0, 17'h1ABCD, 8'h5A, 8'hFF);
    wr_req = 4'b0001;
    settle_check();
    clk_adv();
    wr_req = '0;
    set_rd(2, 17'h1ABCD);
    rd_req = 4'b0100;
    settle_check();
    chk("lat_rd_gnt", 32'(rd_gnt), 32'b0100);
    clk_adv();
    rd_req = '0;
    settle_check();
    chk("lat_rd_valid", 32'(rd_valid), 32'b0100);
    chk("lat_rd_data",  32'(rd_data),  32'h5A);
    clk_adv();

    // Collision: the write wins, the read follows once the write is gone.
    set_wr(0, 17'h00010, 8'hC3, 8'hFF);
    set_rd(1, 17'h00010);
    wr_req = 4'b0001; rd_req = 4'b0010;
    settle_check();
    chk("col_wr_gnt", 32'(wr_gnt), 32'b0001);
    chk("col_ce0",    32'(CE0), 1);
    chk("col_rd_gnt", 32'(rd_gnt), 0);
    chk("col_ce1",    32'(CE1), 0);
    clk_adv();
    wr_req = '0;
    settle_check();
    chk("col_rd_gnt2", 32'(rd_gnt), 32'b0010);
    clk_adv();
    rd_req = '0;
    settle_check();
    chk("col_rd_valid", 32'(rd_valid), 32'b0010);
    chk("col_rd_data",  32'(rd_data),  32'hC3);
    clk_adv();

    // Starvation guard: three stalls, then the write port yields once.
    wr_req = 4'b0001; rd_req = 4'b0010;
    for (int c = 0; c < SMAX; c++) begin
      set_wr(0, 17'h00010, DB'(8'hA0 + c), 8'hFF);
      settle_check();
      chk($sformatf("stv_c%0d_ce0", c), 32'(CE0), 1);
      chk($sformatf("stv_c%0d_rd_gnt", c), 32'(rd_gnt), 0);
      clk_adv();
    end
    set_wr(0, 17'h00010, 8'hA3, 8'hFF);
    settle_check();
    chk("stv_yield_ce0",    32'(CE0), 0);
    chk("stv_yield_wr_gnt", 32'(wr_gnt), 0);
    chk("stv_yield_rd_gnt", 32'(rd_gnt), 32'b0010);
    clk_adv();
    settle_check();
    chk("stv_rd_valid",  32'(rd_valid), 32'b0010);
    chk("stv_rd_data",   32'(rd_data), 32'hA2);
    chk("stv_after_ce0", 32'(CE0), 1);
    chk("stv_after_rd_gnt", 32'(rd_gnt), 0);
    clk_adv();
    wr_req = '0; rd_req = '0;
    settle_check();
    clk_adv();

    // Write with an all-zero mask does not block a read of the same address.
    set_wr(0, 17'h00020, 8'h77, 8'h00);
    set_rd(1, 17'h00020);
    wr_req = 4'b0001; rd_req = 4'b0010;
    settle_check();
    chk("msk_wr_gnt", 32'(wr_gnt), 32'b0001);
    chk("msk_rd_gnt", 32'(rd_gnt), 32'b0010);
    chk("msk_ce0",    32'(CE0), 1);
    chk("msk_ce1",    32'(CE1), 1);
    clk_adv();
    wr_req = '0; rd_req = '0;
    settle_check();
    chk("msk_rd_valid", 32'(rd_valid), 32'b0010);
    chk("msk_rd_data",  32'(rd_data), 32'(init_val(32'h20)));
    clk_adv();

    // Randomized traffic on a small address set to provoke collisions and stalls.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        set_wr(i, AB'($urandom_range(0, 3)), DB'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'h00 : DB'($urandom));
        set_rd(i, AB'($urandom_range(0, 3)));
      end
      wr_req = N'($urandom_range(0, 15));
      rd_req = N'($urandom_range(0, 15));
      settle_check();
      clk_adv();
    end
    wr_req = '0; rd_req = '0;
    settle_check();
    clk_adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_b_17abits_arbiter.md
Name: sram_b_17abits_arbiter

Overview:
- Shares one 1w:1r 17-bit-address, 8-bit-data SRAM bank (write port 0, read port 1, per-bit write mask) between NREQ requesters.
- Runs independent round-robin arbitration on the write port and the read port.
- Prevents same-cycle read/write to the same address, and routes one-cycle-latency read data back to the issuing requester.
- Sits between accelerator PLM clients and the sram_b memory instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ABITS, 17, address width
- DBITS, 8, data width (one mask bit per data bit)
- STALL_MAX, 3, consecutive collision stalls of a read before the write port yields one cycle

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTN  in  1  asynchronous active-low reset
- wr_req  in  NREQ  per-requester write request; held until granted
- wr_gnt  out  NREQ  one-hot write grant; the write issues in the granting cycle
- wr_addr  in  NREQ*ABITS  packed write addresses; requester i at [i*ABITS +: ABITS]
- wr_data  in  NREQ*DBITS  packed write data
- wr_mask  in  NREQ*DBITS  packed per-bit write enables
- rd_req  in  NREQ  per-requester read request; held until granted
- rd_gnt  out  NREQ  one-hot read grant
- rd_addr  in  NREQ*ABITS  packed read addresses
- rd_valid  out  NREQ  one-hot, registered; asserted the cycle after rd_gnt
- rd_data  out  DBITS  read data, broadcast to all requesters; qualified by rd_valid
- CE0  out  1  memory write-port enable
- A0  out  ABITS  memory write address
- D0  out  DBITS  memory write data
- WE0  out  1  memory write enable
- WEM0  out  DBITS  memory write mask
- CE1  out  1  memory read-port enable
- A1  out  ABITS  memory read address
- Q1  in  DBITS  memory read data, valid one cycle after CE1

Behaviour:
- Reset (RSTN low, asynchronous):
  - wr_ptr=0, rd_ptr=0, stall_cnt=0, rd_valid=0.
  - All grants and CE0/WE0/CE1 deassert combinationally while reset is active.
  - An in-flight read is dropped; no rd_valid follows reset release.
- Write arbitration (combinational):
  - Scan from wr_ptr upward, modulo NREQ. The first i with wr_req[i] wins, unless yield is set (see starvation).
  - Winner: wr_gnt[i]=1, CE0=WE0=1, A0/D0/WEM0 = requester i fields.
  - No winner: CE0=WE0=0, A0/D0/WEM0=0.
  - On a grant edge, wr_ptr <= (i+1) mod NREQ.
- Read arbitration (combinational): same scan from rd_ptr. Winner j drives CE1=1 and A1=rd_addr[j].
- Collision:
  - Condition: the write winner exists, the read winner exists, A0==A1, and WEM0 != 0.
  - Result: the read is blocked. CE1=0, rd_gnt=0, rd_ptr unchanged, stall_cnt increments (saturating at STALL_MAX).
  - A write with WEM0==0 still issues but does not block the read.
- Starvation guard:
  - yield = (stall_cnt==STALL_MAX).
  - While yield: no write grant (CE0=0); the read winner is granted; stall_cnt <= 0.
  - Any read grant clears stall_cnt. A cycle with no read request also clears stall_cnt.
- Read return: on a read grant to j, rd_valid <= onehot(j) next cycle, else rd_valid <= 0. rd_data = Q1 combinationally (no extra register).
- Throughput: one write and one read per cycle when addresses differ. Read latency is exactly 1 cycle from grant.
- Requests may drop without a grant; no state is kept per ungranted request.
- NREQ==1 degenerates to pass-through with collision and starvation logic intact.

Decomposition:
- Package sram_b_arb_pkg: ABITS/DBITS defaults, STALL_MAX default, onehot/index helper function.
- Sub-module rr_arbiter (req vector + pointer -> one-hot grant + index, pointer update on accept), instantiated twice (write, read).

Test Plan:
- Reset check: RSTN low mid-read (rd_gnt[1] this cycle) -> rd_valid stays 0 after release; wr_ptr/rd_ptr=0; first grant goes to requester 0.
- Round-robin: all 4 wr_req held for 8 cycles -> wr_gnt sequence 0,1,2,3,0,1,2,3; CE0=1 every cycle with A0 matching the granted addresses.
- Read latency and routing: rd_req[2] with addr 0x1ABCD, memory holding 0x5A -> rd_gnt[2] at cycle t; rd_valid=4'b0100 and rd_data=0x5A at t+1.
- Collision: wr_req[0] and rd_req[1], both addr 0x00010, WEM0=0xFF -> write issues; rd_gnt=0, CE1=0; next cycle (write gone) the read is granted and returns the new data.
- Starvation: writes to 0x00010 every cycle plus a read of 0x00010 -> read stalled 3 cycles, 4th cycle CE0=0 and rd_gnt asserted, stall_cnt returns to 0.
- Masked-off write: WEM0=0x00 at the same address as the read -> both grants issue in the same cycle.
